// File: rtl/numberentry_pkg.sv
// Shared definitions for the number entry / number display pair:
// character-index constants and the entry FSM state encoding.
package numberentry_pkg;

  localparam int unsigned IDX_WIDTH = 7;

  localparam logic [IDX_WIDTH-1:0] IDX_DIGIT0   = 7'd28;
  localparam logic [IDX_WIDTH-1:0] IDX_DIGIT9   = 7'd37;
  localparam logic [IDX_WIDTH-1:0] IDX_LETTER_A = 7'd1;
  localparam logic [IDX_WIDTH-1:0] IDX_LETTER_F = 7'd6;

  // state | meaning
  // EDIT  | accepting characters and edit actions
  // HOLD  | committed value offered to the consumer
  localparam logic [0:0] EDIT = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

endpackage

// File: rtl/numberentry_index_to_digit.sv
// Character index to hex digit decoder; inverse of the display-side
// digit-to-index mapping. '0'..'9' at 28..37, 'A'..'F' at 1..6.
module numberentry_index_to_digit
  import numberentry_pkg::*;
(
  input  logic [IDX_WIDTH-1:0] char_index,
  output logic [3:0]           digit,
  output logic                 digit_valid
);

  logic [IDX_WIDTH-1:0] num_off;
  logic [IDX_WIDTH-1:0] let_off;

  // Decode index to digit; anything outside the two ranges is invalid.
  always_comb begin
    num_off     = char_index - IDX_DIGIT0;
    let_off     = char_index - IDX_LETTER_A + 7'd10;
    digit       = 4'd0;
    digit_valid = 1'b0;
    if (char_index >= IDX_DIGIT0 && char_index <= IDX_DIGIT9) begin
      digit       = num_off[3:0];
      digit_valid = 1'b1;
    end else if (char_index >= IDX_LETTER_A && char_index <= IDX_LETTER_F) begin
      digit       = let_off[3:0];
      digit_valid = 1'b1;
    end
  end

endmodule

// File: rtl/numberentry.sv
// Number entry block: collects hex digits from a character source into a
// live edit register and hands committed values to a consumer.
// Optional build macro NUMBERENTRY_AUTOCOMMIT_EN: the digit that fills the
// edit register also commits it in the same cycle.
module numberentry
  import numberentry_pkg::*;
#(
  parameter int SYMBOLS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         char_valid,
  input  logic [IDX_WIDTH-1:0]         char_index,
  output logic                         char_ready,
  input  logic                         backspace,
  input  logic                         commit,
  input  logic                         clear,
  output logic [4*SYMBOLS-1:0]         edit_number,
  output logic [$clog2(SYMBOLS+1)-1:0] edit_count,
  output logic [4*SYMBOLS-1:0]         value,
  output logic                         value_valid,
  input  logic                         value_ready,
  output logic                         error
);

  localparam int W  = 4 * SYMBOLS;
  localparam int CW = $clog2(SYMBOLS + 1);

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  edit_q, edit_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  value_q, value_d;
  logic          error_q, error_d;

  logic [3:0]    digit;
  logic          digit_valid;
  logic          char_fire;
  logic [W+3:0]  shifted_in;

  numberentry_index_to_digit u_decode (
    .char_index  (char_index),
    .digit       (digit),
    .digit_valid (digit_valid)
  );

  assign char_ready = (state_q == EDIT);
  assign char_fire  = char_valid & char_ready;
  assign shifted_in = {edit_q, digit};

  // Next-state logic; within one cycle clear beats commit beats backspace
  // beats a character, and a losing character is still consumed.
  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    count_d = count_q;
    value_d = value_q;
    error_d = 1'b0;
    if (state_q == EDIT) begin
      if (clear) begin
        edit_d  = '0;
        count_d = '0;
      end else if (commit) begin
        if (count_q != '0) begin
          value_d = edit_q;
          edit_d  = '0;
          count_d = '0;
          state_d = HOLD;
        end else begin
          error_d = 1'b1;
        end
      end else if (backspace) begin
        if (count_q != '0) begin
          edit_d  = edit_q >> 4;
          count_d = count_q - 1'b1;
        end
      end else if (char_fire) begin
        if (!digit_valid || count_q == CW'(SYMBOLS)) begin
          error_d = 1'b1;
        end else begin
          edit_d  = shifted_in[W-1:0];
          count_d = count_q + 1'b1;
`ifdef NUMBERENTRY_AUTOCOMMIT_EN
          if (count_d == CW'(SYMBOLS)) begin
            value_d = shifted_in[W-1:0];
            edit_d  = '0;
            count_d = '0;
            state_d = HOLD;
          end
`endif
        end
      end
    end else begin
      if (value_ready) state_d = EDIT;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EDIT;
      edit_q  <= '0;
      count_q <= '0;
      value_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      edit_q  <= edit_d;
      count_q <= count_d;
      value_q <= value_d;
      error_q <= error_d;
    end
  end

  assign edit_number = edit_q;
  assign edit_count  = count_q;
  assign value       = value_q;
  assign value_valid = (state_q == HOLD);
  assign error       = error_q;

endmodule
